// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: default bit timing and FSM state type.
package uart_rx_pkg;

   localparam int UART_CLKS_PER_BIT = 104;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK_START,
      ST_READ_BITS,
      ST_CHECK_STOP,
      ST_RECOVER
   } rx_state_e;

   function automatic int half_bit(input int cpb);
      return cpb / 2;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input pin.
module uart_rx_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with start-glitch rejection and framing-error reporting.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       rx,
   output logic       received,
   output logic [7:0] rx_byte,
   output logic       is_receiving,
   output logic       recv_error
);

   localparam int              CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   HALF_M1 = CW'(half_bit(CLKS_PER_BIT) - 1);
   localparam logic [CW-1:0]   BIT_M1  = CW'(CLKS_PER_BIT - 1);

   logic      w_rx_s;
   rx_state_e r_state, w_state;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [2:0] r_idx, w_idx;
   logic [7:0] r_shift, w_shift;
   logic [7:0] r_byte, w_byte;
   logic r_recv, w_recv;
   logic r_err, w_err;
   logic r_busy, w_busy;

   uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .i_async (rx),
      .o_sync  (w_rx_s)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_byte  <= '0;
         r_recv  <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_idx   <= w_idx;
         r_shift <= w_shift;
         r_byte  <= w_byte;
         r_recv  <= w_recv;
         r_err   <= w_err;
         r_busy  <= w_busy;
      end
   end

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_idx   = r_idx;
      w_shift = r_shift;
      w_byte  = r_byte;
      w_recv  = 1'b0;
      w_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_rx_s) begin
               w_state = ST_CHECK_START;
               w_cnt   = HALF_M1;
            end
         end
         ST_CHECK_START: begin
            if (r_cnt != '0) begin
               w_cnt = r_cnt - CW'(1);
            end else if (w_rx_s) begin
               // Line went back high before mid-start: treat as noise.
               w_state = ST_IDLE;
            end else begin
               w_state = ST_READ_BITS;
               w_cnt   = BIT_M1;
               w_idx   = '0;
            end
         end
         ST_READ_BITS: begin
            if (r_cnt != '0) begin
               w_cnt = r_cnt - CW'(1);
            end else begin
               w_shift = {w_rx_s, r_shift[7:1]};
               w_cnt   = BIT_M1;
               if (r_idx == 3'd7) w_state = ST_CHECK_STOP;
               else               w_idx   = r_idx + 3'd1;
            end
         end
         ST_CHECK_STOP: begin
            if (r_cnt != '0) begin
               w_cnt = r_cnt - CW'(1);
            end else if (w_rx_s) begin
               w_byte  = r_shift;
               w_recv  = 1'b1;
               w_state = ST_IDLE;
            end else begin
               w_err   = 1'b1;
               w_state = ST_RECOVER;
            end
         end
         ST_RECOVER: begin
            // Hold off until a break/low line releases, so no false start fires.
            if (w_rx_s) w_state = ST_IDLE;
         end
         default: w_state = ST_IDLE;
      endcase
      w_busy = (w_state == ST_CHECK_START) || (w_state == ST_READ_BITS) ||
               (w_state == ST_CHECK_STOP);
   end

   assign received     = r_recv;
   assign rx_byte      = r_byte;
   assign is_receiving = r_busy;
   assign recv_error   = r_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 8 clocks per bit.
module tb_uart_rx;

   localparam int CPB = 8;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       rx;
   logic       received;
   logic [7:0] rx_byte;
   logic       is_receiving;
   logic       recv_error;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int n_overlap = 0;
   int t0;
   int rcyc[$];
   logic [7:0] rbyte[$];
   int ecyc[$];

   typedef struct {
      logic [7:0] data;
      int         gap;
      logic [7:0] exp_byte;
      int         exp_spacing;
   } vec_t;
   vec_t tbl[4];

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .rx           (rx),
      .received     (received),
      .rx_byte      (rx_byte),
      .is_receiving (is_receiving),
      .recv_error   (recv_error)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (received) begin
         rcyc.push_back(cyc);
         rbyte.push_back(rx_byte);
      end
      if (recv_error) ecyc.push_back(cyc);
      if (received && recv_error) n_overlap++;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_neg(input int n);
      do @(negedge clock); while (cyc < n);
   endtask

   // Called just after a rising edge; returns just after edge start+10*CPB.
   task automatic frame(input logic [7:0] d, input logic sb);
      rx = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(posedge clock);
         #1 rx = d[i];
      end
      repeat (CPB) @(posedge clock);
      #1 rx = sb;
      repeat (CPB) @(posedge clock);
      #1;
   endtask

   task automatic clear_q();
      rcyc.delete();
      rbyte.delete();
      ecyc.delete();
   endtask

   task automatic check_good(input string nm, input logic [7:0] exp);
      check({nm, " rx count"}, rcyc.size(), 1);
      check({nm, " err count"}, ecyc.size(), 0);
      if (rcyc.size() > 0) begin
         check({nm, " rx time"}, rcyc[0] - t0, 79);
         check({nm, " rx byte"}, rbyte[0], exp);
      end
   endtask

   initial begin
      int prev;
      tbl[0] = '{8'h0E, 0,  8'h0E, 0};
      tbl[1] = '{8'hCD, 10, 8'hCD, 80};
      tbl[2] = '{8'h00, 0,  8'h00, 0};
      tbl[3] = '{8'hFF, 10, 8'hFF, 80};

      rx = 1'b1;
      reset_n = 1'b0;
      idle(3);
      check("reset received", received, 0);
      check("reset is_receiving", is_receiving, 0);
      check("reset recv_error", recv_error, 0);
      check("reset rx_byte", rx_byte, 8'h00);
      reset_n = 1'b1;
      idle(5);

      // single frame with busy-window timing
      clear_q();
      t0 = cyc;
      fork
         frame(8'h42, 1'b1);
         begin
            wait_neg(t0 + 2); check("t1 busy@2", is_receiving, 0);
            wait_neg(t0 + 3); check("t1 busy@3", is_receiving, 1);
            wait_neg(t0 + 78); check("t1 busy@78", is_receiving, 1);
            wait_neg(t0 + 79); check("t1 busy@79", is_receiving, 0);
         end
      join
      idle(10);
      check_good("t1", 8'h42);
      check("t1 held byte", rx_byte, 8'h42);

      // back-to-back and extreme-pattern frames
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         clear_q();
         t0 = cyc;
         frame(tbl[k].data, 1'b1);
         if (tbl[k].gap > 0) idle(tbl[k].gap);
         check_good($sformatf("vec%0d", k), tbl[k].exp_byte);
         if (tbl[k].exp_spacing != 0 && rcyc.size() > 0)
            check($sformatf("vec%0d spacing", k), rcyc[0] - prev, tbl[k].exp_spacing);
         if (rcyc.size() > 0) prev = rcyc[0];
         check($sformatf("vec%0d held byte", k), rx_byte, tbl[k].exp_byte);
      end

      // start-bit glitch
      clear_q();
      t0 = cyc;
      rx = 1'b0;
      fork
         begin idle(2); rx = 1'b1; end
         begin
            wait_neg(t0 + 3); check("glitch busy@3", is_receiving, 1);
            wait_neg(t0 + 6); check("glitch busy@6", is_receiving, 1);
            wait_neg(t0 + 7); check("glitch busy@7", is_receiving, 0);
         end
      join
      idle(20);
      check("glitch rx count", rcyc.size(), 0);
      check("glitch busy idle", is_receiving, 0);
      clear_q();
      t0 = cyc;
      frame(8'h44, 1'b1);
      idle(10);
      check_good("post-glitch", 8'h44);

      // framing error then break
      clear_q();
      t0 = cyc;
      frame(8'h55, 1'b0);
      idle(10);
      check("ferr busy in recover", is_receiving, 0);
      idle(20);
      rx = 1'b1;
      idle(20);
      check("ferr err count", ecyc.size(), 1);
      if (ecyc.size() > 0) check("ferr err time", ecyc[0] - t0, 79);
      check("ferr rx count", rcyc.size(), 0);
      check("ferr held byte", rx_byte, 8'h44);
      clear_q();
      t0 = cyc;
      frame(8'h10, 1'b1);
      idle(10);
      check_good("post-ferr", 8'h10);

      // reset during data bit 4
      clear_q();
      t0 = cyc;
      fork
         frame(8'h3C, 1'b1);
         begin
            wait_neg(t0 + 44);
            check("midrst busy before", is_receiving, 1);
            reset_n = 1'b0;
            #1;
            check("midrst received", received, 0);
            check("midrst is_receiving", is_receiving, 0);
            check("midrst recv_error", recv_error, 0);
            check("midrst rx_byte", rx_byte, 8'h00);
            wait_neg(t0 + 82);
            reset_n = 1'b1;
         end
      join
      idle(10);
      check("midrst rx count", rcyc.size(), 0);
      check("midrst err count", ecyc.size(), 0);
      clear_q();
      t0 = cyc;
      frame(8'hA5, 1'b1);
      idle(10);
      check_good("post-rst", 8'hA5);

      check("pulse overlap", n_overlap, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
